gauss_row_window_ctrl: RTL

- Sequencer for the 8-bit, 11-tap pixel shift-register line used by the SIFT Gaussian row filter.
- Accepts a raster pixel stream with a valid/ready handshake and drives the tap line's data input and shift enable.
- Replicates the first and last pixel of each row as border padding, so every image column yields exactly one full-window result.
- Flags each cycle the tap window is fully populated with same-row data, and reports the window's centre column and row.

---
 rtl/gauss_row_window_ctrl_if.sv | 29 ++
 rtl/gauss_row_window_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/gauss_row_window_ctrl_if.sv
// Pixel-stream and tap-line control bundle between the row-window sequencer and its neighbours.
// The pixel source and window consumer use master; the controller uses slave.
interface gauss_row_window_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 10,
    parameter int unsigned RW = 9
);
    logic          sof;
    logic          pix_valid;
    logic [DW-1:0] pix_in;
    logic          pix_ready;
    logic          sr_en;
    logic [DW-1:0] sr_din;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          frame_done;
    logic          busy;

    modport master (
        output sof, pix_valid, pix_in,
        input  pix_ready, sr_en, sr_din, win_valid, win_col, win_row, frame_done, busy
    );

    modport slave (
        input  sof, pix_valid, pix_in,
        output pix_ready, sr_en, sr_din, win_valid, win_col, win_row, frame_done, busy
    );
endinterface

// File: rtl/gauss_row_window_ctrl.sv
// Sequencer for the Gaussian row filter tap line: feeds pixels, replicates row borders,
// and flags every cycle the TAPS-long window holds same-row data.
module gauss_row_window_ctrl #(
    parameter int unsigned DW   = 8,
    parameter int unsigned TAPS = 11,
    parameter int unsigned COLS = 640,
    parameter int unsigned ROWS = 480,
    parameter int unsigned CW   = 10,
    parameter int unsigned RW   = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    gauss_row_window_ctrl_if.slave  bus
);
    localparam int unsigned HALF = (TAPS - 1) / 2;
    localparam int unsigned PW   = $clog2(HALF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PIX,
        S_LPAD,
        S_RUN,
        S_RPAD,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_shift_idx;
    logic [CW-1:0] r_col_in;
    logic [PW-1:0] r_pad_cnt;
    logic [DW-1:0] r_last_pix;

    logic          w_pix_ready;
    logic          w_sr_en;
    logic [DW-1:0] w_sr_din;
    logic          w_accept;
    logic          w_win_full;

    // Handshake and tap-line drive; sof blanks both for the restart cycle.
    always_comb begin
        w_pix_ready = 1'b0;
        w_sr_en     = 1'b0;
        w_sr_din    = '0;
        if (!bus.sof) begin
            case (r_state)
                S_WAIT_PIX, S_RUN: begin
                    w_pix_ready = 1'b1;
                    if (bus.pix_valid) begin
                        w_sr_en  = 1'b1;
                        w_sr_din = bus.pix_in;
                    end
                end
                S_LPAD, S_RPAD: begin
                    w_sr_en  = 1'b1;
                    w_sr_din = r_last_pix;
                end
                default: ;
            endcase
        end
    end

    assign w_accept   = w_pix_ready & bus.pix_valid;
    assign w_win_full = (r_shift_idx >= CW'(TAPS - 1));

    assign bus.pix_ready  = w_pix_ready;
    assign bus.sr_en      = w_sr_en;
    assign bus.sr_din     = w_sr_din;
    assign bus.win_valid  = w_sr_en & w_win_full;
    assign bus.win_col    = w_win_full ? (r_shift_idx - CW'(TAPS - 1)) : '0;
    assign bus.win_row    = r_row;
    assign bus.frame_done = (r_state == S_DONE);
    assign bus.busy       = (r_state != S_IDLE);

    // Row/column/pad bookkeeping; shift_idx restarts each row so stale taps never qualify.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_shift_idx <= '0;
            r_col_in    <= '0;
            r_pad_cnt   <= '0;
            r_last_pix  <= '0;
        end else if (bus.sof) begin
            r_state     <= S_WAIT_PIX;
            r_row       <= '0;
            r_shift_idx <= '0;
            r_col_in    <= '0;
            r_pad_cnt   <= '0;
        end else begin
            if (w_sr_en) begin
                r_shift_idx <= r_shift_idx + CW'(1);
            end
            case (r_state)
                S_IDLE: ;
                S_WAIT_PIX: begin
                    if (w_accept) begin
                        r_last_pix  <= bus.pix_in;
                        r_col_in    <= CW'(1);
                        r_shift_idx <= CW'(1);
                        r_pad_cnt   <= PW'(HALF);
                        r_state     <= S_LPAD;
                    end
                end
                S_LPAD: begin
                    r_pad_cnt <= r_pad_cnt - PW'(1);
                    if (r_pad_cnt == PW'(1)) begin
                        if (r_col_in == CW'(COLS)) begin
                            r_pad_cnt <= PW'(HALF);
                            r_state   <= S_RPAD;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_last_pix <= bus.pix_in;
                        r_col_in   <= r_col_in + CW'(1);
                        if (r_col_in == CW'(COLS - 1)) begin
                            r_pad_cnt <= PW'(HALF);
                            r_state   <= S_RPAD;
                        end
                    end
                end
                S_RPAD: begin
                    r_pad_cnt <= r_pad_cnt - PW'(1);
                    if (r_pad_cnt == PW'(1)) begin
                        if (r_row == RW'(ROWS - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row       <= r_row + RW'(1);
                            r_shift_idx <= '0;
                            r_state     <= S_WAIT_PIX;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
